pipe_rca: RTL and testbench
===========================

Name: pipe_rca

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; the successor to the team's fixed 4-bit combinational RCA.
- Operand width is split into SLICE-bit slices, one slice per pipeline stage, with carry registered between stages.
- Valid/ready handshake on both sides and full backpressure. Sits in the datapath as the arithmetic unit feeding accumulators and comparators.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits added per stage; STAGES = WIDTH/SLICE, so latency is STAGES cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept an operand beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0: a+b+cin; 1: a-b-cin
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  add: carry-out; sub: NOT borrow-out (1 means no borrow)
- ovf  out  1  two's-complement signed overflow of the result

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 once reset is released.
- Transfer rules: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Operand conditioning at stage 0: b_eff = sub ? ~b : b; c_eff = sub ? ~cin : cin.
- Stage k (0..STAGES-1):
  - Adds slice k of a and b_eff with the carry registered by stage k-1 (c_eff for k=0).
  - Registers its slice sum and carry-out.
  - Carries forward the unprocessed upper slices of a and b_eff, and the sub flag.
- Result assembly: the last stage holds the full sum.
  - cout = final carry.
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- Latency: a beat accepted in cycle N appears with out_valid=1 in cycle N+STAGES when nothing stalls. Throughput is 1 beat/cycle.
- Flow control, per stage with bubble collapse:
  - Stage k loads when its valid bit is 0 or stage k+1 loads this cycle.
  - The last stage loads when out_valid=0 or out_ready=1.
  - in_ready = stage-0 load condition.
  - A stalled stage holds its data and its carry unchanged.
- Outputs are registered directly from the last stage. sum, cout and ovf hold stable while out_valid=1 and out_ready=0.
- Back-to-back operations: an add and a sub in consecutive cycles must not interfere, because sub travels with its beat.
- Simultaneous input accept and output consume on a full pipeline: no loss, no duplication, order preserved.
- Reset mid-operation: all in-flight beats are discarded. No out_valid may appear after rst_n deasserts until new beats are accepted.
- Boundary cases:
  - All-ones + 1 wraps to 0 with cout=1.
  - SLICE == WIDTH gives a single-stage design with 1-cycle latency.
- No X propagation: idle-stage data may be don't-care, but out_valid must never be X after reset.

Decomposition:
- Shared package (pipe_rca_pkg):
  - Default WIDTH/SLICE constants.
  - A function computing STAGES.
  - The op-code encoding OP_ADD=0 / OP_SUB=1.
- One sub-module, rca_slice: combinational SLICE-bit ripple-carry adder with inputs a, b, cin and outputs sum, cout, instantiated once per stage.
- Stage registers and handshake live in pipe_rca via a generate loop.

Test Plan (WIDTH=16, SLICE=4, latency 4):
- Add: a=0x0001, b=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x0002, cout=0, ovf=0.
- Carry chain across all slices: a=0xFFFE, b=0x0001, cin=1 -> sum=0x0000, cout=1, ovf=0.
- Signed overflow, add: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- Sub: a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0.
- Sub: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: stream 8 random beats with in_valid=1 and out_ready toggled 0/1 randomly -> all 8 results appear in order and match a reference model. Results hold while stalled. in_ready=0 only when all 4 stages are full and out_ready=0.
- Reset mid-stream: accept 3 beats, pull rst_n low for 1 cycle -> out_valid stays 0 afterwards until a new beat's latency has elapsed. in_ready=1 immediately after release.

Source files
------------

// File: rtl/pipe_rca_pkg.sv
// pipe_rca_pkg: shared constants and helpers for the pipelined ripple-carry
// adder/subtractor.
//   DEF_WIDTH / DEF_SLICE : default operand width and bits per pipeline stage
//   op_e                  : operation encoding carried on the 'sub' input
//   calc_stages()         : number of pipeline stages (= latency in cycles)
package pipe_rca_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // WIDTH must be an exact multiple of SLICE; each stage handles one slice.
  function automatic int calc_stages(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/pipe_rca_if.sv
// pipe_rca_if: operand/result handshake bundle for pipe_rca.
//   Input side : in_valid, in_ready, a, b, cin, sub
//   Output side: out_valid, out_ready, sum, cout, ovf
//   modport master : the producer/consumer around the adder (drives operands,
//                    accepts results)
//   modport slave  : the adder itself
interface pipe_rca_if
  import pipe_rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/rca_slice.sv
// rca_slice: purely combinational SLICE-bit ripple-carry adder.
//   a, b : slice operands
//   cin  : carry into bit 0
//   sum  : slice sum
//   cout : carry out of the top bit
module rca_slice
  import pipe_rca_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] c;

  always_comb begin
    // NOTE: every variable gets a value before the loop so no path through
    // this block leaves it unassigned; otherwise a latch would be inferred.
    c   = '0;
    sum = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[SLICE];

endmodule

// File: rtl/pipe_rca.sv
// pipe_rca: pipelined ripple-carry adder/subtractor.
//   WIDTH-bit operands are processed SLICE bits per stage, giving
//   STAGES = WIDTH/SLICE cycles of latency at one beat per cycle.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : pipe_rca_if.slave
//                  in_valid/in_ready/a/b/cin/sub   operand beat
//                  out_valid/out_ready/sum/cout/ovf result beat
//   sub=0: sum = a + b + cin, cout = carry-out
//   sub=1: sum = a - b - cin, cout = NOT borrow-out
//   ovf  : two's-complement overflow of the result
module pipe_rca
  import pipe_rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input logic       clk,
  input logic       rst_n,
  pipe_rca_if.slave bus
);

  localparam int STAGES = calc_stages(WIDTH, SLICE);

  logic [STAGES-1:0] vld;   // per-stage valid bits
  logic [STAGES-1:0] ld;    // per-stage load enables

  // Subtraction is folded into the operands at entry, so the op travels
  // implicitly with its beat as b_eff/c_eff; later stages never see 'sub'.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign b_eff = (bus.sub == OP_SUB) ? ~bus.b   : bus.b;
  assign c_eff = (bus.sub == OP_SUB) ? ~bus.cin : bus.cin;

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = vld[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : stage
    localparam int IW = WIDTH - k * SLICE;    // operand bits still unprocessed
    localparam int SW = (k + 1) * SLICE;      // sum bits known after this stage

    logic [IW-1:0]    a_in;
    logic [IW-1:0]    b_in;
    logic             c_in;
    logic             v_in;
    logic [SW-1:0]    s_next;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;

    logic             vld_q;
    logic [SW-1:0]    s_q;
    logic             c_q;

    // Bubble collapse: a stage may load unless it and every stage after it
    // are full while the consumer is stalling. Written in closed form so the
    // enables do not form a combinational chain.
    assign ld[k]  = bus.out_ready || !(&vld[STAGES-1:k]);
    assign vld[k] = vld_q;

    if (k == 0) begin : src
      assign a_in   = bus.a;
      assign b_in   = b_eff;
      assign c_in   = c_eff;
      assign v_in   = bus.in_valid;
      assign s_next = slice_sum;
    end else begin : src
      assign a_in   = stage[k-1].fwd.a_q;
      assign b_in   = stage[k-1].fwd.b_q;
      assign c_in   = stage[k-1].c_q;
      assign v_in   = vld[k-1];
      assign s_next = {slice_sum, stage[k-1].s_q};
    end

    rca_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .a    (a_in[SLICE-1:0]),
      .b    (b_in[SLICE-1:0]),
      .cin  (c_in),
      .sum  (slice_sum),
      .cout (slice_cout)
    );

    // Partial sum and carry are reset so the result outputs read 0 after
    // reset; a stalled stage keeps both unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is always updated with non-blocking '<=' so
      // every register samples the pre-edge value of its neighbours.
      if (!rst_n) begin
        vld_q <= 1'b0;
        s_q   <= '0;
        c_q   <= 1'b0;
      end else if (ld[k]) begin
        vld_q <= v_in;
        s_q   <= s_next;
        c_q   <= slice_cout;
      end
    end

    if (k < STAGES - 1) begin : fwd
      logic [IW-SLICE-1:0] a_q;
      logic [IW-SLICE-1:0] b_q;

      // NOTE: pure datapath registers carry no reset; their contents are only
      // observed when the matching valid bit is set, which is reset.
      always_ff @(posedge clk) begin
        if (ld[k]) begin
          a_q <= a_in[IW-1:SLICE];
          b_q <= b_in[IW-1:SLICE];
        end
      end
    end else begin : last
      logic ovf_q;

      // The top slice holds the operand sign bits, so overflow is resolved
      // here: like-signed operands producing an opposite-signed result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (ld[k]) begin
          ovf_q <= (a_in[IW-1] == b_in[IW-1]) &&
                   (slice_sum[SLICE-1] != a_in[IW-1]);
        end
      end

      assign bus.sum  = s_q;
      assign bus.cout = c_q;
      assign bus.ovf  = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipe_rca.sv
// tb_pipe_rca: self-checking bench for pipe_rca (WIDTH=16, SLICE=4).
// Expected results are pushed to a queue when a beat is accepted and popped
// when the DUT hands a result over.
module tb_pipe_rca;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int LAT   = WIDTH / SLICE;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  typedef struct {
    logic ov;
    logic rdy;
    int   inflight;
    logic popped;
    res_t act;
    res_t exp;
  } step_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    res_t             want;
    string            name;
  } vec_t;

  logic clk;
  logic rst_n;
  res_t exp_q[$];
  int   tests;
  int   fails;

  pipe_rca_if #(.WIDTH(WIDTH)) bus ();

  pipe_rca #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    logic [WIDTH-1:0] be;
    logic             ce;
    logic [WIDTH:0]   t;
    res_t             r;
    be    = sub ? ~b : b;
    ce    = sub ? ~cin : cin;
    t     = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, ce};
    r.sum  = t[WIDTH-1:0];
    r.cout = t[WIDTH];
    r.ovf  = (a[WIDTH-1] == be[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  // One clock of stimulus; returns what was observed and, when a result was
  // consumed, the expectation popped for it ('x when none was outstanding).
  task automatic step(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                      input logic icin, input logic isub, input logic ordy, output step_t r);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.cin       = icin;
    bus.sub       = isub;
    bus.out_ready = ordy;
    #1;
    r.ov       = bus.out_valid;
    r.rdy      = bus.in_ready;
    r.inflight = exp_q.size();
    r.act      = {bus.sum, bus.cout, bus.ovf};
    r.popped   = 1'b0;
    r.exp      = 'x;
    if (r.ov === 1'b1 && ordy) begin
      r.popped = 1'b1;
      if (exp_q.size() > 0) r.exp = exp_q.pop_front();
    end
    if (iv && r.rdy === 1'b1) exp_q.push_back(model(ia, ib, icin, isub));
  endtask

  // Idles with out_ready=1 until a result is consumed; lat=-1 on timeout.
  task automatic wait_result(output step_t r, output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, r);
      if (r.popped) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    tests++;
    if ({bus.sum, bus.cout, bus.ovf} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b want 0/0/0", bus.sum, bus.cout, bus.ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t  v[6];
    step_t r;
    int    lat;
    v[0] = '{16'h0001, 16'h0001, 1'b0, 1'b0, '{16'h0002, 1'b0, 1'b0}, "add_basic"};
    v[1] = '{16'hFFFE, 16'h0001, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0}, "carry_chain"};
    v[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}, "add_ovf"};
    v[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0}, "sub_borrow"};
    v[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}, "sub_ovf"};
    v[5] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}, "wrap_all_ones"};
    foreach (v[i]) begin
      step(1'b1, v[i].a, v[i].b, v[i].cin, v[i].sub, 1'b1, r);
      tests++;
      if (r.rdy !== 1'b1) begin
        fails++;
        $display("FAIL %s_accept: in_ready got %b want 1", v[i].name, r.rdy);
      end
      wait_result(r, lat);
      tests++;
      if (lat != LAT) begin
        fails++;
        $display("FAIL %s_latency: got %0d cycles want %0d", v[i].name, lat, LAT);
      end
      tests++;
      if (r.act !== v[i].want) begin
        fails++;
        $display("FAIL %s: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", v[i].name,
                 r.act.sum, r.act.cout, r.act.ovf, v[i].want.sum, v[i].want.cout, v[i].want.ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t r;
    int    got;
    got = 0;
    for (int i = 0; i < 8 + LAT + 4; i++) begin
      if (i < 8)
        step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'(i % 2), 1'b1, r);
      else
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, r);
      if (i < 8) begin
        tests++;
        if (r.rdy !== 1'b1) begin
          fails++;
          $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, r.rdy);
        end
      end
      if (r.popped) begin
        got++;
        tests++;
        if (r.act !== r.exp) begin
          fails++;
          $display("FAIL b2b_result[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", got,
                   r.act.sum, r.act.cout, r.act.ovf, r.exp.sum, r.exp.cout, r.exp.ovf);
        end
      end
    end
    tests++;
    if (got != 8) begin
      fails++;
      $display("FAIL b2b_count: got %0d results want 8", got);
    end
  endtask

  task automatic test_backpressure();
    step_t r;
    int    sent;
    int    got;
    int    cyc;
    logic  ordy;
    logic  stalled;
    res_t  held;
    sent    = 0;
    got     = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while ((sent < 8 || got < 8) && cyc < 300) begin
      // Hold the consumer off at first so the pipeline fills completely.
      ordy = (cyc < 6) ? 1'b0 : 1'($urandom_range(0, 1));
      step(sent < 8, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy, r);
      tests++;
      if (r.rdy !== (ordy || (r.inflight < LAT))) begin
        fails++;
        $display("FAIL bp_in_ready[%0d]: got %b want %b (in flight %0d, out_ready %b)",
                 cyc, r.rdy, ordy || (r.inflight < LAT), r.inflight, ordy);
      end
      if (stalled) begin
        tests++;
        if (r.ov !== 1'b1 || r.act !== held) begin
          fails++;
          $display("FAIL bp_hold[%0d]: got valid=%b sum=%h cout=%b ovf=%b want valid=1 sum=%h cout=%b ovf=%b",
                   cyc, r.ov, r.act.sum, r.act.cout, r.act.ovf, held.sum, held.cout, held.ovf);
        end
      end
      stalled = (r.ov === 1'b1) && !ordy;
      held    = r.act;
      if (sent < 8 && r.rdy === 1'b1) sent++;
      if (r.popped) begin
        got++;
        tests++;
        if (r.act !== r.exp) begin
          fails++;
          $display("FAIL bp_result[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", got,
                   r.act.sum, r.act.cout, r.act.ovf, r.exp.sum, r.exp.cout, r.exp.ovf);
        end
      end
      cyc++;
    end
    tests++;
    if (got != 8 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL bp_count: got %0d results (%0d pending) want 8 (0 pending)", got, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    step_t r;
    int    lat;
    res_t  want;
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0, 1'b0, r);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    exp_q.delete();
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || {bus.sum, bus.cout, bus.ovf} !== '0) begin
      fails++;
      $display("FAIL midrst_clear: got valid=%b sum=%h cout=%b ovf=%b want 0/0000/0/0",
               bus.out_valid, bus.sum, bus.cout, bus.ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready);
    end
    for (int i = 0; i < LAT + 3; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, r);
      tests++;
      if (r.ov !== 1'b0) begin
        fails++;
        $display("FAIL midrst_no_valid[%0d]: got %b want 0", i, r.ov);
      end
    end
    want = model(16'h1234, 16'h0FFF, 1'b1, 1'b1);
    step(1'b1, 16'h1234, 16'h0FFF, 1'b1, 1'b1, 1'b1, r);
    wait_result(r, lat);
    tests++;
    if (lat != LAT || r.act !== want) begin
      fails++;
      $display("FAIL midrst_new_beat: got lat=%0d sum=%h cout=%b ovf=%b want lat=%0d sum=%h cout=%b ovf=%b",
               lat, r.act.sum, r.act.cout, r.act.ovf, LAT, want.sum, want.cout, want.ovf);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
